// File: rtl/payload_dispatch_arbiter_if.sv
// Requester handshake, decoded-message strobes and statistics counters of the
// payload dispatch arbiter, bundled for connection between producer and arbiter.
interface payload_dispatch_arbiter_if #(
    parameter int PAYLOAD_W = 512,
    parameter int NUM_REQ   = 4
);
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*PAYLOAD_W-1:0] req_payload;
    logic [NUM_REQ-1:0]           req_ready;
    logic                         dec_stall;
    logic [4:0]                   type_en;
    logic                         add_valid;
    logic                         delete_valid;
    logic                         cancel_valid;
    logic                         replace_valid;
    logic                         exec_valid;
    logic [PAYLOAD_W-1:0]         dec_payload;
    logic [SRC_W-1:0]             dec_src;
    logic [15:0]                  unknown_cnt;
    logic [15:0]                  filtered_cnt;
    logic [31:0]                  msg_cnt;

    modport master (
        output req_valid, req_payload, dec_stall, type_en,
        input  req_ready, add_valid, delete_valid, cancel_valid, replace_valid,
               exec_valid, dec_payload, dec_src, unknown_cnt, filtered_cnt, msg_cnt
    );

    modport slave (
        input  req_valid, req_payload, dec_stall, type_en,
        output req_ready, add_valid, delete_valid, cancel_valid, replace_valid,
               exec_valid, dec_payload, dec_src, unknown_cnt, filtered_cnt, msg_cnt
    );
endinterface

// File: rtl/payload_dispatch_arbiter.sv
// Round-robin arbiter across NUM_REQ payload requesters; the granted message is
// registered, its type byte decoded into one-cycle strobes, and statistics kept.
module payload_dispatch_arbiter #(
    parameter int PAYLOAD_W = 512,
    parameter int NUM_REQ   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    payload_dispatch_arbiter_if.slave bus
);
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    // Strobe bit order matches type_en: {E,U,X,D,A}
    function automatic logic [4:0] type_onehot(input logic [7:0] t);
        case (t)
            8'h41:   type_onehot = 5'b00001;
            8'h44:   type_onehot = 5'b00010;
            8'h58:   type_onehot = 5'b00100;
            8'h55:   type_onehot = 5'b01000;
            8'h45:   type_onehot = 5'b10000;
            default: type_onehot = 5'b00000;
        endcase
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [SRC_W-1:0]     rr_ptr;
    logic [NUM_REQ-1:0]   upper_vld;
    logic [NUM_REQ-1:0]   pick_vec;
    logic [NUM_REQ-1:0]   pick_oh;
    logic                 grant_any;
    logic [SRC_W-1:0]     grant_idx;
    logic [SRC_W-1:0]     ptr_nxt;
    logic [PAYLOAD_W-1:0] grant_payload;
    logic [4:0]           type_hit;

    logic [4:0]           strb_p0;
    logic [PAYLOAD_W-1:0] dec_payload_p0;
    logic [SRC_W-1:0]     dec_src_p0;
    logic [15:0]          unknown_cnt_p0;
    logic [15:0]          filtered_cnt_p0;
    logic [31:0]          msg_cnt_p0;

    // Requests at or above rr_ptr take priority; otherwise wrap to the lowest index.
    always_comb begin
        upper_vld     = bus.req_valid & ~((ONE << rr_ptr) - ONE);
        pick_vec      = (|upper_vld) ? upper_vld : bus.req_valid;
        pick_oh       = pick_vec & (~pick_vec + ONE);
        grant_any     = rst_n & ~bus.dec_stall & (|bus.req_valid);
        grant_idx     = '0;
        grant_payload = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) begin
                grant_idx     = SRC_W'(i);
                grant_payload = bus.req_payload[i*PAYLOAD_W +: PAYLOAD_W];
            end
        end
        ptr_nxt  = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);
        type_hit = type_onehot(grant_payload[PAYLOAD_W-1 -: 8]);
    end

    assign bus.req_ready = grant_any ? pick_oh : '0;

    // Stage p0: accepted message registered; strobes live for one cycle only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr          <= '0;
            strb_p0         <= '0;
            dec_payload_p0  <= '0;
            dec_src_p0      <= '0;
            unknown_cnt_p0  <= '0;
            filtered_cnt_p0 <= '0;
            msg_cnt_p0      <= '0;
        end else begin
            strb_p0 <= '0;
            if (grant_any) begin
                rr_ptr         <= ptr_nxt;
                dec_payload_p0 <= grant_payload;
                dec_src_p0     <= grant_idx;
                msg_cnt_p0     <= msg_cnt_p0 + 32'd1;
                strb_p0        <= type_hit & bus.type_en;
                if (type_hit == 5'b00000)
                    unknown_cnt_p0 <= sat_inc16(unknown_cnt_p0);
                else if ((type_hit & bus.type_en) == 5'b00000)
                    filtered_cnt_p0 <= sat_inc16(filtered_cnt_p0);
            end
        end
    end

    assign bus.add_valid     = strb_p0[0];
    assign bus.delete_valid  = strb_p0[1];
    assign bus.cancel_valid  = strb_p0[2];
    assign bus.replace_valid = strb_p0[3];
    assign bus.exec_valid    = strb_p0[4];
    assign bus.dec_payload   = dec_payload_p0;
    assign bus.dec_src       = dec_src_p0;
    assign bus.unknown_cnt   = unknown_cnt_p0;
    assign bus.filtered_cnt  = filtered_cnt_p0;
    assign bus.msg_cnt       = msg_cnt_p0;
endmodule

// File: tb/tb_payload_dispatch_arbiter.sv
// Bench for payload_dispatch_arbiter: directed and random traffic compared each
// cycle against a queue-free behavioural model of the dispatch rules.
module tb_payload_dispatch_arbiter;
    localparam int PW = 512;
    localparam int NR = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    payload_dispatch_arbiter_if #(.PAYLOAD_W(PW), .NUM_REQ(NR)) bus ();

    payload_dispatch_arbiter #(.PAYLOAD_W(PW), .NUM_REQ(NR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [PW-1:0] pay [NR];
    logic [NR-1:0] cur_valid;
    logic          cur_stall;
    logic [4:0]    cur_en;

    // Reference state
    int            m_ptr;
    logic [PW-1:0] m_pay;
    int            m_src;
    logic [4:0]    m_strb;
    int            m_unk;
    int            m_filt;
    logic [31:0]   m_msg;

    logic [7:0] codes [5] = '{8'h41, 8'h44, 8'h58, 8'h55, 8'h45};

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] ref_type(input logic [7:0] t);
        logic [4:0] r = '0;
        for (int b = 0; b < 5; b++) if (t == codes[b]) r[b] = 1'b1;
        return r;
    endfunction

    function automatic int ref_winner();
        if (!rst_n || cur_stall || cur_valid == '0) return -1;
        for (int k = 0; k < NR; k++)
            if (cur_valid[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_pay = '0; m_src = 0; m_strb = '0;
        m_unk = 0; m_filt = 0; m_msg = '0;
    endtask

    task automatic check_outputs(input string ph);
        chk({ph, "_strobes"}, {bus.exec_valid, bus.replace_valid, bus.cancel_valid,
                               bus.delete_valid, bus.add_valid}, m_strb);
        chk({ph, "_dec_payload"}, bus.dec_payload, m_pay);
        chk({ph, "_dec_src"}, bus.dec_src, m_src);
        chk({ph, "_unknown_cnt"}, bus.unknown_cnt, m_unk);
        chk({ph, "_filtered_cnt"}, bus.filtered_cnt, m_filt);
        chk({ph, "_msg_cnt"}, bus.msg_cnt, m_msg);
    endtask

    task automatic drive(input logic [NR-1:0] v, input logic s, input logic [4:0] en);
        cur_valid = v; cur_stall = s; cur_en = en;
        bus.req_valid = v;
        bus.dec_stall = s;
        bus.type_en   = en;
        for (int i = 0; i < NR; i++) bus.req_payload[i*PW +: PW] = pay[i];
    endtask

    task automatic set_pay(input int i, input logic [7:0] t);
        for (int j = 0; j < PW/32; j++) pay[i][j*32 +: 32] = $urandom;
        pay[i][PW-1 -: 8] = t;
    endtask

    function automatic logic [7:0] rand_type();
        int r = $urandom_range(0, 6);
        if (r < 5) return codes[r];
        return 8'($urandom);
    endfunction

    // Called just after a falling edge with inputs driven; ends on the next falling edge.
    task automatic step();
        int w;
        logic [4:0] hit;
        #1;
        w = ref_winner();
        chk("req_ready", bus.req_ready, (w < 0) ? NR'(0) : (NR'(1) << w));
        check_outputs("pre");
        @(posedge clk);
        #1;
        if (w >= 0) begin
            m_pay  = pay[w];
            m_src  = w;
            m_msg  = m_msg + 32'd1;
            hit    = ref_type(pay[w][PW-1 -: 8]);
            m_strb = hit & cur_en;
            if (hit == 5'b0) m_unk = (m_unk < 65535) ? m_unk + 1 : 65535;
            else if ((hit & cur_en) == 5'b0) m_filt = (m_filt < 65535) ? m_filt + 1 : 65535;
            m_ptr = (w + 1) % NR;
        end else begin
            m_strb = '0;
        end
        check_outputs("post");
        @(negedge clk);
    endtask

    initial begin
        int f0;
        int u0;
        model_reset();
        for (int i = 0; i < NR; i++) set_pay(i, rand_type());
        rst_n = 1'b0;
        drive(4'b1111, 1'b0, 5'h1F);
        #2;
        chk("reset_req_ready", bus.req_ready, 0);
        check_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single add message from requester 0
        set_pay(0, 8'h41);
        drive(4'b0001, 1'b0, 5'h1F);
        step();
        chk("single_add", bus.add_valid, 1);
        chk("single_src", bus.dec_src, 0);
        chk("single_msg", bus.msg_cnt, 1);
        drive(4'b0000, 1'b0, 5'h1F);
        step();
        chk("single_add_drop", bus.add_valid, 0);

        // Park pointer at 0, then fairness over eight back-to-back grants
        drive(4'b1000, 1'b0, 5'h1F);
        step();
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NR; i++) set_pay(i, rand_type());
            drive(4'b1111, 1'b0, 5'h1F);
            step();
            chk("fair_order", bus.dec_src, k % NR);
        end
        chk("fair_msg", bus.msg_cnt, 10);

        // Stall right after accepting from requester 2
        set_pay(2, 8'h44);
        drive(4'b0100, 1'b0, 5'h1F);
        step();
        drive(4'b1111, 1'b1, 5'h1F);
        #1;
        chk("stall_strobe", bus.delete_valid, 1);
        chk("stall_ready", bus.req_ready, 0);
        step();
        step();
        step();
        drive(4'b1111, 1'b0, 5'h1F);
        step();
        chk("stall_release_src", bus.dec_src, 3);

        // Recognised-but-disabled, then unrecognised
        f0 = m_filt;
        u0 = m_unk;
        set_pay(0, 8'h58);
        drive(4'b0001, 1'b0, 5'b11011);
        step();
        chk("filtered_inc", bus.filtered_cnt, f0 + 1);
        chk("filtered_nostrobe", bus.cancel_valid, 0);
        set_pay(1, 8'h5A);
        drive(4'b0010, 1'b0, 5'h1F);
        step();
        chk("unknown_inc", bus.unknown_cnt, u0 + 1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NR; i++) set_pay(i, rand_type());
            drive(NR'($urandom), ($urandom_range(0, 3) == 0), 5'($urandom));
            step();
        end

        // Reset one cycle after an accept
        for (int i = 0; i < NR; i++) set_pay(i, 8'h45);
        drive(4'b1111, 1'b0, 5'h1F);
        step();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_ready", bus.req_ready, 0);
        check_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b0110, 1'b0, 5'h1F);
        step();
        chk("midrst_first_src", bus.dec_src, 1);

        // Unknown counter saturation
        for (int i = 0; i < NR; i++) set_pay(i, 8'h5A);
        drive(4'b1111, 1'b0, 5'h1F);
        repeat (65537) step();
        chk("unknown_sat", bus.unknown_cnt, 16'hFFFF);
        chk("sat_msg", bus.msg_cnt, m_msg);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/payload_dispatch_arbiter.md
PAYLOAD_DISPATCH_ARBITER -- requirements
Module: payload_dispatch_arbiter

Interface
REQ-001 SHALL have parameter PAYLOAD_W, default 512, the payload width in bits; message type byte = payload[PAYLOAD_W-1 -: 8].
REQ-002 SHALL have parameter NUM_REQ, default 4, the number of ingress requesters (2..8).
REQ-003 SHALL have ports:
  clk  in  1  clock, all logic on rising edge
  rst_n  in  1  reset, asynchronous, active-low
  req_valid  in  NUM_REQ  per-requester payload valid
  req_payload  in  NUM_REQ*PAYLOAD_W  requester i payload at [i*PAYLOAD_W +: PAYLOAD_W]
  req_ready  out  NUM_REQ  per-requester accept, combinational
  dec_stall  in  1  downstream hold; blocks new grants
  type_en  in  5  per-type enable {E,U,X,D,A} = bits [4:0]
  add_valid  out  1  one-cycle strobe, 'A' (0x41) payload on dec_payload
  delete_valid  out  1  one-cycle strobe, 'D' (0x44)
  cancel_valid  out  1  one-cycle strobe, 'X' (0x58)
  replace_valid  out  1  one-cycle strobe, 'U' (0x55)
  exec_valid  out  1  one-cycle strobe, 'E' (0x45)
  dec_payload  out  PAYLOAD_W  registered payload of last accepted message
  dec_src  out  clog2(NUM_REQ)  requester index of dec_payload
  unknown_cnt  out  16  count of accepted unrecognised types, saturating
  filtered_cnt  out  16  count of accepted recognised-but-disabled types, saturating
  msg_cnt  out  32  count of all accepted messages, wraps

Function
REQ-004 SHALL grant at most one requester per cycle; grant only when dec_stall=0 and at least one req_valid=1.
REQ-005 SHALL select round-robin: search starts at rr_ptr, ascending index with wrap at NUM_REQ-1 -> 0; first valid index wins.
REQ-006 SHALL drive req_ready[g]=1 only for granted g, all other bits 0; req_ready depends combinationally on req_valid, rr_ptr, dec_stall only.
REQ-007 SHALL accept a message on the rising edge where req_valid[g] & req_ready[g]; on accept rr_ptr <= (g+1) mod NUM_REQ; otherwise rr_ptr holds.
REQ-008 SHALL register dec_payload and dec_src on accept; both hold value when no accept.
REQ-009 SHALL assert exactly one type strobe in the cycle after accept when type byte matches a recognised type and the matching type_en bit (sampled at accept) is 1; strobe high for exactly one cycle.
REQ-010 SHALL assert no strobe when no accept occurred in the previous cycle; strobes mutually exclusive.
REQ-011 SHALL, for an accepted recognised type with type_en bit 0, emit no strobe and increment filtered_cnt by 1, saturating at 0xFFFF.
REQ-012 SHALL, for an accepted unrecognised type byte, emit no strobe and increment unknown_cnt by 1, saturating at 0xFFFF.
REQ-013 SHALL increment msg_cnt by 1 on every accept regardless of type, wrapping 0xFFFFFFFF -> 0.
REQ-014 SHALL sustain one accept per cycle under continuous valid with dec_stall=0; latency accept edge -> strobe = 1 cycle.
REQ-015 SHALL, when dec_stall rises, still emit the strobe for a message accepted on the previous edge; no new accept while dec_stall=1.
REQ-016 SHALL not require req_valid to persist; a requester deasserting valid before grant loses nothing and is not granted.

Reset
REQ-017 SHALL on rst_n=0, asynchronously: rr_ptr=0, all strobes=0, dec_payload=0, dec_src=0, unknown_cnt=0, filtered_cnt=0, msg_cnt=0; req_ready=0 while rst_n=0.
REQ-018 SHALL discard any in-flight accept when reset asserts mid-operation; no strobe in the first cycle after reset release.

Verification
REQ-019 Single: req_valid=0001, payload type 0x41, type_en=11111 -> req_ready=0001, next cycle add_valid=1 for 1 cycle, dec_src=0, msg_cnt=1.
REQ-020 Fairness: req_valid=1111 held 8 cycles, dec_stall=0 -> grant order 0,1,2,3,0,1,2,3; msg_cnt=8.
REQ-021 Stall: accept from requester 2 at edge N, dec_stall=1 from cycle N -> strobe in cycle N+1, req_ready=0000 until dec_stall=0, then grant 3 if valid.
REQ-022 Filter/unknown: type 0x58 with type_en[2]=0 -> no strobe, filtered_cnt=1; type 0x5A -> no strobe, unknown_cnt=1.
REQ-023 Saturation/wrap: 65537 unknown messages -> unknown_cnt=0xFFFF; msg_cnt preloaded to 0xFFFFFFFF via 2^32-1 accepts then one more -> 0.
REQ-024 Reset mid-stream: rst_n low one cycle after accept -> strobe suppressed, all counters 0, rr_ptr=0, first grant after release to lowest valid index.
